// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// FSM state encoding and the default operand width.
package serial_subtractor_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor_bit.sv
// One-bit full subtractor: d = a - b - bin, borrow out on bout.
// Ports: i_a, i_b, i_bin in; o_d, o_bout out.
module full_subtractor_bit (
   input  logic i_a,
   input  logic i_b,
   input  logic i_bin,
   output logic o_d,
   output logic o_bout
);

   logic w_x;

   assign w_x    = i_a ^ i_b;
   assign o_d    = w_x ^ i_bin;
   assign o_bout = (~i_a & i_b) | (~w_x & i_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first: diff = a - b - borrow_in.
// Ports: clk, rst_n, start/a/b/borrow_in in; busy, done, diff, borrow_out.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] w_res_next;
   logic [WIDTH-1:0] r_diff;
   logic             r_bout;
   logic             r_br;
   logic [CW-1:0]    r_cnt;
   logic             w_d;
   logic             w_bnext;
   logic             w_last;

   full_subtractor_bit u_fs (
      .i_a    (r_a_sr[0]),
      .i_b    (r_b_sr[0]),
      .i_bin  (r_br),
      .o_d    (w_d),
      .o_bout (w_bnext)
   );

   assign w_last     = (r_cnt == LAST);
   assign w_res_next = {w_d, r_res[WIDTH-1:1]};

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         ST_IDLE:  if (start) w_state_next = ST_SHIFT;
         ST_SHIFT: if (w_last) w_state_next = ST_DONE;
         ST_DONE:  w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_a_sr  <= '0;
         r_b_sr  <= '0;
         r_res   <= '0;
         r_diff  <= '0;
         r_bout  <= 1'b0;
         r_br    <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         unique case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a_sr <= a;
                  r_b_sr <= b;
                  r_br   <= borrow_in;
                  r_cnt  <= '0;
               end
            end
            ST_SHIFT: begin
               r_a_sr <= r_a_sr >> 1;
               r_b_sr <= r_b_sr >> 1;
               r_br   <= w_bnext;
               r_res  <= w_res_next;
               // Capture the final bit directly so the result is
               // already stable while done is high.
               if (w_last) begin
                  r_diff <= w_res_next;
                  r_bout <= w_bnext;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy       = (r_state == ST_SHIFT) || (r_state == ST_DONE);
   assign done       = (r_state == ST_DONE);
   assign diff       = r_diff;
   assign borrow_out = r_bout;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor. It computes diff = a - b - borrow_in one bit per clock, LSB first, using a single full-subtractor cell. It is the sequential, inverse-operation companion to the team's combinational ripple-carry adder. It is intended for area-constrained datapaths that have a start/done handshake and where latency is acceptable.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled only in IDLE
a  input  WIDTH  minuend; sampled on accepted start
b  input  WIDTH  subtrahend; sampled on accepted start
borrow_in  input  1  initial borrow; sampled on accepted start
busy  output  1  high while in SHIFT or DONE state
done  output  1  one-cycle pulse when result is valid
diff  output  WIDTH  result a - b - borrow_in (mod 2^WIDTH)
borrow_out  output  1  final borrow (1 when a < b + borrow_in, unsigned)

Behaviour:
- Reset (async on rst_n low): state=IDLE; busy=0; done=0; diff=0; borrow_out=0; internal shift regs, borrow reg and bit counter cleared. Reset mid-operation aborts the operation with no done pulse.
- FSM states:
  - IDLE --start=1--> SHIFT. On that edge: latch a and b into shift regs, borrow reg <= borrow_in, count <= 0.
  - SHIFT: one bit per cycle. d = a_sr[0] ^ b_sr[0] ^ br; br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br). a_sr and b_sr shift right; d shifts into result reg at MSB; count++. When count == WIDTH-1 (last bit) --> DONE.
  - DONE: done=1 for exactly this cycle. diff <= result reg and borrow_out <= br are registered so they are valid in the same cycle as done. Unconditional transition to IDLE.
- Latency: start accepted at edge N, done high in cycle N+WIDTH+1. Throughput is one operation per WIDTH+2 cycles.
- start while busy (SHIFT or DONE) is ignored: no restart, and operands are not re-sampled.
- diff and borrow_out hold their last result until the next DONE, or until reset. They do not change during SHIFT.
- Input changes to a, b and borrow_in after the accepted start have no effect on the operation in progress.
- Counter width: $clog2(WIDTH). No wrap beyond WIDTH-1.
- Signed interpretation: diff is correct two's-complement. Signed overflow is not flagged.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH constant.
- One natural sub-module: full_subtractor_bit, a combinational cell with inputs a, b, bin and outputs d, bout. The top level holds the FSM, shift registers, counter and output registers.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, borrow_in=0, start pulse -> done after 9 cycles; diff=0x02, borrow_out=0.
- a=0x03, b=0x05, borrow_in=0 -> diff=0xFE, borrow_out=1.
- a=0x00, b=0x00, borrow_in=1 -> diff=0xFF, borrow_out=1. Then a=0xFF, b=0x00, borrow_in=0 -> diff=0xFF, borrow_out=0.
- Start a=0x10, b=0x01; pulse start with a=0x80, b=0x80 at cycle 3 while busy -> only one done pulse; diff=0x0F, borrow_out=0.
- Start a=0x40, b=0x20; drop rst_n at cycle 4 -> busy=0, done never pulses, diff=0x00. Then a new start with a=0x40, b=0x20 -> diff=0x20.
- Self-checking sweep: 200 random a/b/borrow_in against the reference model {borrow_out, diff} = {1'b0, a} - b - borrow_in; also check done is exactly one cycle wide every time.
